// File: rtl/tlp_rx_decoder.sv
// rtl/tlp_rx_decoder.sv - PCIe RX TLP decoder: MRd/MWr headers to one request, then write payload one DW at a time
module tlp_rx_decoder #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [63:0]       rx_tdata,
  input  logic [7:0]        rx_tkeep,
  input  logic              rx_tlast,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_burst_length,
  output logic [3:0]        req_first_be,
  output logic [3:0]        req_last_be,
  output logic [7:0]        req_tag,
  output logic [15:0]       req_id,
  output logic [31:0]       wdata,
  output logic              wdata_valid,
  output logic              wdata_last,
  input  logic              wdata_ready,
  output logic              err_unsupported,
  output logic              err_malformed
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR2 = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              write_q, write_d;
  logic              dw4_q, dw4_d;
  logic              extra_q, extra_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        fbe_q, fbe_d;
  logic [3:0]        lbe_q, lbe_d;
  logic [7:0]        tag_q, tag_d;
  logic [15:0]       rid_q, rid_d;
  logic [31:0]       buf0_q, buf0_d;
  logic [31:0]       buf1_q, buf1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_unsup_q, err_unsup_d;
  logic              err_mal_q, err_mal_d;

  logic              rx_fire;
  logic              hdr_ok;
  logic [LEN_W-1:0]  hdr_len;
  logic [63:0]       addr64;
  logic              addr_hi_bad;
  logic              tkeep_unused;

  assign tkeep_unused = ^rx_tkeep;

  assign rx_fire     = rx_tvalid & rx_tready;
  assign hdr_ok      = (rx_tdata[28:24] == 5'b00000);
  assign hdr_len     = (rx_tdata[9:0] == 10'd0) ? LEN_W'(1024) : LEN_W'(rx_tdata[9:0]);
  // 4DW second beat carries addr[63:32] in the low DW and addr[31:0] in the high DW
  assign addr64      = dw4_q ? {rx_tdata[31:0], rx_tdata[63:34], 2'b00}
                             : {32'd0, rx_tdata[31:2], 2'b00};
  assign addr_hi_bad = dw4_q && ((addr64 >> ADDR_W) != 64'd0);

  assign rx_tready = !reset && ((state_q == S_IDLE) || (state_q == S_HDR2) ||
                                (state_q == S_DROP) ||
                                ((state_q == S_DATA) && (cnt_q == 2'd0)));

  assign req_valid        = (state_q == S_REQ);
  assign req_write        = write_q;
  assign req_addr         = addr_q;
  assign req_burst_length = len_q;
  assign req_first_be     = fbe_q;
  assign req_last_be      = lbe_q;
  assign req_tag          = tag_q;
  assign req_id           = rid_q;
  assign wdata            = buf0_q;
  assign wdata_valid      = (state_q == S_DATA) && (cnt_q != 2'd0);
  assign wdata_last       = wdata_valid && (rem_q == LEN_W'(1));
  assign err_unsupported  = err_unsup_q;
  assign err_malformed    = err_mal_q;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    dw4_d       = dw4_q;
    extra_d     = extra_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rem_d       = rem_q;
    fbe_d       = fbe_q;
    lbe_d       = lbe_q;
    tag_d       = tag_q;
    rid_d       = rid_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    cnt_d       = cnt_q;
    err_unsup_d = 1'b0;
    err_mal_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          write_d = rx_tdata[30];
          dw4_d   = rx_tdata[29];
          len_d   = hdr_len;
          rid_d   = rx_tdata[63:48];
          tag_d   = rx_tdata[47:40];
          lbe_d   = rx_tdata[39:36];
          fbe_d   = rx_tdata[35:32];
          extra_d = 1'b0;
          cnt_d   = 2'd0;
          if (!hdr_ok) begin
            err_unsup_d = 1'b1;
            state_d     = rx_tlast ? S_IDLE : S_DROP;
          end else if (rx_tlast) begin
            err_mal_d = 1'b1;
          end else begin
            state_d = S_HDR2;
          end
        end
      end

      S_HDR2: begin
        if (rx_fire) begin
          addr_d = addr64[ADDR_W-1:0];
          rem_d  = len_q;
          if (addr_hi_bad) begin
            err_unsup_d = 1'b1;
            state_d     = rx_tlast ? S_IDLE : S_DROP;
          end else if (write_q && dw4_q) begin
            if (rx_tlast) begin
              err_mal_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_REQ;
            end
          end else if (write_q) begin
            // MWr32 header beat already carries payload DW0
            buf0_d  = rx_tdata[63:32];
            cnt_d   = 2'd1;
            state_d = S_REQ;
            if (rx_tlast && (len_q != LEN_W'(1))) begin
              err_mal_d = 1'b1;
              rem_d     = LEN_W'(1);
            end else if (!rx_tlast && (len_q == LEN_W'(1))) begin
              err_mal_d = 1'b1;
              extra_d   = 1'b1;
            end
          end else begin
            state_d = S_REQ;
            if (!rx_tlast) begin
              err_mal_d = 1'b1;
              extra_d   = 1'b1;
            end
          end
        end
      end

      S_REQ: begin
        if (req_ready) begin
          if (write_q) begin
            state_d = S_DATA;
          end else begin
            state_d = extra_q ? S_DROP : S_IDLE;
            extra_d = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (cnt_q != 2'd0) begin
          if (wdata_ready) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
            rem_d  = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = extra_q ? S_DROP : S_IDLE;
              extra_d = 1'b0;
            end
          end
        end else if (rx_fire) begin
          buf0_d = rx_tdata[31:0];
          buf1_d = rx_tdata[63:32];
          cnt_d  = (rem_q == LEN_W'(1)) ? 2'd1 : 2'd2;
          // Early tlast shrinks the burst so the last received DW carries wdata_last
          if (rx_tlast && (rem_q > LEN_W'(2))) begin
            err_mal_d = 1'b1;
            rem_d     = LEN_W'(2);
          end else if (!rx_tlast && (rem_q <= LEN_W'(2))) begin
            err_mal_d = 1'b1;
            extra_d   = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (rx_fire && rx_tlast) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      dw4_q       <= 1'b0;
      extra_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      fbe_q       <= 4'd0;
      lbe_q       <= 4'd0;
      tag_q       <= 8'd0;
      rid_q       <= 16'd0;
      buf0_q      <= 32'd0;
      buf1_q      <= 32'd0;
      cnt_q       <= 2'd0;
      err_unsup_q <= 1'b0;
      err_mal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      dw4_q       <= dw4_d;
      extra_q     <= extra_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      fbe_q       <= fbe_d;
      lbe_q       <= lbe_d;
      tag_q       <= tag_d;
      rid_q       <= rid_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
      err_unsup_q <= err_unsup_d;
      err_mal_q   <= err_mal_d;
    end
  end

endmodule

// File: tb/tb_tlp_rx_decoder.sv
// tb/tb_tlp_rx_decoder.sv - directed vector bench for tlp_rx_decoder
module tb_tlp_rx_decoder;

  localparam logic [15:0] RID = 16'hCAFE;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rx_tdata = 64'd0;
  logic [7:0]  rx_tkeep = 8'hFF;
  logic        rx_tlast = 1'b0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic        req_write;
  logic [31:0] req_addr;
  logic [10:0] req_burst_length;
  logic [3:0]  req_first_be;
  logic [3:0]  req_last_be;
  logic [7:0]  req_tag;
  logic [15:0] req_id;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_last;
  logic        wdata_ready = 1'b1;
  logic        err_unsupported;
  logic        err_malformed;

  tlp_rx_decoder #(.ADDR_W(32), .LEN_W(11)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_burst_length(req_burst_length),
    .req_first_be(req_first_be), .req_last_be(req_last_be),
    .req_tag(req_tag), .req_id(req_id),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_last(wdata_last),
    .wdata_ready(wdata_ready),
    .err_unsupported(err_unsupported), .err_malformed(err_malformed)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    int          pdw;
    logic [31:0] ahi;
    logic [31:0] alo;
    logic [7:0]  tag;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    bit          tog;
    int          e_req;
    logic        e_wr;
    logic [31:0] e_addr;
    int          e_blen;
    int          e_nw;
    int          e_unsup;
    int          e_mal;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    int          blen;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [7:0]  tag;
    logic [15:0] id;
  } req_t;

  vec_t        vecs[9];
  logic [31:0] dws[0:1100];
  int          ndw;
  req_t        reqs[$];
  logic [31:0] wd_q[$];
  logic        wl_q[$];
  int          n_unsup;
  int          n_mal;
  int          checks = 0;
  int          errors = 0;
  bit          wr_toggle = 1'b0;
  logic        wr_level = 1'b1;

  always @(negedge sys_clk) begin
    wdata_ready = wr_toggle ? ~wdata_ready : wr_level;
  end

  // Monitor samples just before each rising edge, when inputs and outputs are settled
  always begin
    req_t r;
    @(negedge sys_clk);
    #4;
    if (req_valid && req_ready) begin
      r.wr   = req_write;
      r.addr = req_addr;
      r.blen = int'(req_burst_length);
      r.fbe  = req_first_be;
      r.lbe  = req_last_be;
      r.tag  = req_tag;
      r.id   = req_id;
      reqs.push_back(r);
    end
    if (wdata_valid && wdata_ready) begin
      wd_q.push_back(wdata);
      wl_q.push_back(wdata_last);
    end
    if (err_unsupported) n_unsup++;
    if (err_malformed) n_mal++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int k, input logic [7:0] tag);
    return {tag, 24'(k)};
  endfunction

  task automatic setv(input int i, input logic [1:0] fmt, input logic [4:0] typ,
                      input logic [9:0] len, input int pdw, input logic [31:0] ahi,
                      input logic [31:0] alo, input logic [7:0] tag, input logic [3:0] fbe,
                      input logic [3:0] lbe, input bit tog, input int e_req, input logic e_wr,
                      input logic [31:0] e_addr, input int e_blen, input int e_nw,
                      input int e_unsup, input int e_mal);
    vecs[i].fmt = fmt;   vecs[i].typ = typ;   vecs[i].len = len;   vecs[i].pdw = pdw;
    vecs[i].ahi = ahi;   vecs[i].alo = alo;   vecs[i].tag = tag;   vecs[i].fbe = fbe;
    vecs[i].lbe = lbe;   vecs[i].tog = tog;   vecs[i].e_req = e_req; vecs[i].e_wr = e_wr;
    vecs[i].e_addr = e_addr; vecs[i].e_blen = e_blen; vecs[i].e_nw = e_nw;
    vecs[i].e_unsup = e_unsup; vecs[i].e_mal = e_mal;
  endtask

  task automatic build(input vec_t v);
    ndw = 0;
    dws[ndw] = {1'b0, v.fmt, v.typ, 14'd0, v.len}; ndw++;
    dws[ndw] = {RID, v.tag, v.lbe, v.fbe};        ndw++;
    if (v.fmt[0]) begin
      dws[ndw] = v.ahi; ndw++;
    end
    dws[ndw] = v.alo; ndw++;
    for (int k = 0; k < v.pdw; k++) begin
      dws[ndw] = pattern(k, v.tag); ndw++;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int   t;
    logic r;
    rx_tdata  = d;
    rx_tlast  = last;
    rx_tvalid = 1'b1;
    t = 0;
    do begin
      #1;
      r = rx_tready;
      @(posedge sys_clk);
      t++;
    end while (!r && t < 3000);
    @(negedge sys_clk);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL rx_accept timeout actual=not_ready required=ready");
    end
  endtask

  task automatic send_dws(input int max_beats);
    int b = 0;
    for (int i = 0; i < ndw && b < max_beats; i += 2) begin
      send_beat({(i + 1 < ndw) ? dws[i + 1] : 32'd0, dws[i]}, (i + 2 >= ndw));
      b++;
    end
  endtask

  task automatic clear_mon();
    reqs.delete();
    wd_q.delete();
    wl_q.delete();
    n_unsup = 0;
    n_mal = 0;
  endtask

  initial begin
    // fmt typ len pdw ahi alo tag fbe lbe tog | req wr addr blen nw unsup mal
    setv(0, 2'b00, 5'd0,      10'd1,  0,    32'h0, 32'h0000_1000, 8'h05, 4'hF, 4'h0, 0, 1, 1'b0, 32'h0000_1000, 1,    0,    0, 0);
    setv(1, 2'b10, 5'd0,      10'd3,  3,    32'h0, 32'h0000_2000, 8'h11, 4'hF, 4'hF, 0, 1, 1'b1, 32'h0000_2000, 3,    3,    0, 0);
    setv(2, 2'b11, 5'd0,      10'd2,  2,    32'h0, 32'h0000_3000, 8'h22, 4'hF, 4'h3, 1, 1, 1'b1, 32'h0000_3000, 2,    2,    0, 0);
    setv(3, 2'b01, 5'd0,      10'd1,  0,    32'h1, 32'h0000_4000, 8'h33, 4'hF, 4'h0, 0, 0, 1'b0, 32'h0,         0,    0,    1, 0);
    setv(4, 2'b10, 5'b01010,  10'd4,  4,    32'h0, 32'h0000_6000, 8'h44, 4'hF, 4'hF, 0, 0, 1'b0, 32'h0,         0,    0,    1, 0);
    setv(5, 2'b10, 5'd0,      10'd0,  1024, 32'h0, 32'h0000_8000, 8'h55, 4'hF, 4'hF, 0, 1, 1'b1, 32'h0000_8000, 1024, 1024, 0, 0);
    setv(6, 2'b11, 5'd0,      10'd4,  2,    32'h0, 32'h0000_9000, 8'h66, 4'hF, 4'hF, 0, 1, 1'b1, 32'h0000_9000, 4,    2,    0, 1);
    setv(7, 2'b01, 5'd0,      10'd16, 0,    32'h0, 32'hABCD_0008, 8'h77, 4'h3, 4'hC, 0, 1, 1'b0, 32'hABCD_0008, 16,   0,    0, 0);
    setv(8, 2'b10, 5'd0,      10'd1,  1,    32'h0, 32'h0000_A004, 8'h88, 4'h1, 4'h0, 0, 1, 1'b1, 32'h0000_A004, 1,    1,    0, 0);

    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_rx_tready", rx_tready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_wdata_ctl", {wdata_valid, wdata_last, err_unsupported, err_malformed}, 0);
    chk("rst_req_regs", {req_addr, req_burst_length, req_tag, req_id, req_first_be, req_last_be}, 0);
    chk("rst_wdata", wdata, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    #1;
    chk("idle_rx_tready", rx_tready, 1);
    @(negedge sys_clk);

    for (int i = 0; i < 9; i++) begin
      int bad;
      clear_mon();
      wr_toggle = vecs[i].tog;
      build(vecs[i]);
      send_dws(1000);
      repeat (15) @(negedge sys_clk);
      wr_toggle = 1'b0;
      chk($sformatf("v%0d_req_cnt", i), reqs.size(), vecs[i].e_req);
      if (vecs[i].e_req != 0 && reqs.size() > 0) begin
        chk($sformatf("v%0d_req_write", i), reqs[0].wr, vecs[i].e_wr);
        chk($sformatf("v%0d_req_addr", i), reqs[0].addr, vecs[i].e_addr);
        chk($sformatf("v%0d_req_len", i), reqs[0].blen, vecs[i].e_blen);
        chk($sformatf("v%0d_req_be", i), {reqs[0].fbe, reqs[0].lbe}, {vecs[i].fbe, vecs[i].lbe});
        chk($sformatf("v%0d_req_tag_id", i), {reqs[0].tag, reqs[0].id}, {vecs[i].tag, RID});
      end
      chk($sformatf("v%0d_wdata_cnt", i), wd_q.size(), vecs[i].e_nw);
      bad = 0;
      for (int k = 0; k < wd_q.size() && k < vecs[i].e_nw; k++) begin
        if (wd_q[k] !== pattern(k, vecs[i].tag) || wl_q[k] !== (k == vecs[i].e_nw - 1))
          bad++;
      end
      chk($sformatf("v%0d_wdata_seq_bad", i), bad, 0);
      chk($sformatf("v%0d_err_unsup", i), n_unsup, vecs[i].e_unsup);
      chk($sformatf("v%0d_err_mal", i), n_mal, vecs[i].e_mal);
    end

    // tlast on the first header beat
    clear_mon();
    send_beat({RID, 8'h12, 4'h0, 4'hF, 32'h0000_0001}, 1'b1);
    repeat (5) @(negedge sys_clk);
    chk("b0last_req_cnt", reqs.size(), 0);
    chk("b0last_err_mal", n_mal, 1);
    chk("b0last_err_unsup", n_unsup, 0);

    // back-to-back MRd32 then MWr32
    clear_mon();
    build(vecs[0]);
    send_dws(1000);
    build(vecs[8]);
    send_dws(1000);
    repeat (10) @(negedge sys_clk);
    chk("b2b_req_cnt", reqs.size(), 2);
    if (reqs.size() == 2) begin
      chk("b2b_req0", {reqs[0].wr, reqs[0].addr}, {1'b0, 32'h0000_1000});
      chk("b2b_req1", {reqs[1].wr, reqs[1].addr}, {1'b1, 32'h0000_A004});
    end
    chk("b2b_wdata_cnt", wd_q.size(), 1);

    // reset while stalled in DATA with req_ready low
    clear_mon();
    wr_level = 1'b0;
    setv(0, 2'b10, 5'd0, 10'd8, 8, 32'h0, 32'h0000_7000, 8'h99, 4'hF, 4'hF, 0,
         1, 1'b1, 32'h0000_7000, 8, 0, 0, 0);
    build(vecs[0]);
    send_dws(2);
    repeat (3) @(negedge sys_clk);
    #1;
    chk("mid_data_wvalid", wdata_valid, 1);
    @(negedge sys_clk);
    req_ready = 1'b0;
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("midrst_ctl", {rx_tready, req_valid, wdata_valid, wdata_last, err_unsupported, err_malformed}, 0);
    chk("midrst_regs", {req_addr, req_burst_length, req_tag, wdata}, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    req_ready = 1'b1;
    wr_level = 1'b1;
    clear_mon();
    setv(0, 2'b00, 5'd0, 10'd2, 0, 32'h0, 32'h0000_5000, 8'h09, 4'hF, 4'hF, 0,
         1, 1'b0, 32'h0000_5000, 2, 0, 0, 0);
    build(vecs[0]);
    send_dws(1000);
    repeat (8) @(negedge sys_clk);
    chk("postrst_req_cnt", reqs.size(), 1);
    if (reqs.size() == 1) begin
      chk("postrst_req", {reqs[0].wr, reqs[0].addr, reqs[0].tag}, {1'b0, 32'h0000_5000, 8'h09});
      chk("postrst_req_len", reqs[0].blen, 2);
    end
    chk("postrst_wdata_cnt", wd_q.size(), 0);
    chk("postrst_errs", n_unsup + n_mal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
